// File: rtl/mem_requester.sv
// mem_requester: initiator-side valid/ready memory request controller with a credit-protected FWFT read-return FIFO.
//   cmd_*  : client command handshake (cmd_write selects write/read)
//   req_*  : registered request towards the memory responder
//   resp_* : in-order, unstallable read response strobe and data
//   rd_*   : first-word-fall-through read data return to the client
//   busy   : request held, read outstanding, or data buffered
//   err_unexp : sticky flag for a response with no read outstanding
module mem_requester #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              req_valid,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err_unexp
);
    localparam int PW  = $clog2(MAX_OUT);
    localparam int PW1 = PW + 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_nx;

    logic [CW-1:0]     reserved, issued;
    logic [PW:0]       wptr, rptr;
    logic [DATA_W-1:0] mem [MAX_OUT];
    logic              accept, hs, push, pop;

    always_comb begin
        req_valid = state == HOLD;
        hs        = req_valid && req_ready;
        // A read needs a free FIFO slot reserved up front, since its response cannot be stalled.
        cmd_ready = (!req_valid || req_ready) && (cmd_write || reserved < MAX_C);
        accept    = cmd_valid && cmd_ready;
        state_nx  = accept ? HOLD : (hs ? IDLE : state);
    end

    // Pointers carry an extra wrap bit so a full FIFO is distinguishable from empty.
    assign rd_valid = wptr != rptr;
    assign rd_data  = mem[rptr[PW-1:0]];
    assign pop      = rd_valid && rd_ready;
    // A read issued this cycle cannot be answered this cycle, so only registered issued counts.
    assign push     = resp_valid && issued != '0;
    assign busy     = req_valid || issued != '0 || rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            reserved  <= '0;
            issued    <= '0;
            wptr      <= '0;
            rptr      <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (accept) begin
                req_write <= cmd_write;
                req_addr  <= cmd_addr;
                req_wdata <= cmd_wdata;
            end
            reserved  <= reserved + CW'(accept && !cmd_write) - CW'(pop);
            issued    <= issued + CW'(hs && !req_write) - CW'(push);
            wptr      <= wptr + PW1'(push);
            rptr      <= rptr + PW1'(pop);
            err_unexp <= err_unexp || (resp_valid && issued == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= resp_rdata;
    end
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed self-checking bench for mem_requester with a latency-1 in-order responder model.
module tb_mem_requester;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       req_valid, req_write, req_ready = 1'b1;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid = 1'b0;
    logic [7:0] resp_rdata = '0;
    logic       rd_valid, rd_ready = 1'b1;
    logic [7:0] rd_data;
    logic       busy, err_unexp;

    int n_chk = 0, n_fail = 0;
    int rv_cnt = 0, wr_cnt = 0, acc;
    logic hold = 1'b0, inj = 1'b0;
    logic [7:0] tmem [16] = '{default: 8'h00};
    logic [7:0] pend [$];
    logic [7:0] got [$];
    logic [3:0] tbl [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd7};
    logic [7:0] vals [5] = '{8'd10, 8'd20, 8'd30, 8'd55, 8'd77};
    logic       t1w [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] t1a [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    logic [7:0] t1d [6] = '{8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 8'd0};

    mem_requester #(.DATA_W(8), .ADDR_W(4), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // Responder: sees the handshake at the negedge before it happens, answers one cycle after it.
    always @(negedge clk) begin
        if (rst) begin
            resp_valid = 1'b0;
        end else begin
            if (!hold && pend.size() > 0) begin
                resp_valid = 1'b1;
                resp_rdata = pend.pop_front();
            end else begin
                resp_valid = inj;
                resp_rdata = 8'hAA;
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    tmem[req_addr] = req_wdata;
                    wr_cnt++;
                end else begin
                    pend.push_back(tmem[req_addr]);
                end
            end
            if (req_valid) rv_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) got.push_back(rd_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_valid", {31'b0, req_valid}, 0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, err_unexp}, 0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        tick();
        rst = 1'b0;

        // Write then read, back-to-back
        for (int i = 0; i < 6; i++) begin
            tick();
            cmd_valid = 1'b1;
            cmd_write = t1w[i];
            cmd_addr  = t1a[i];
            cmd_wdata = t1d[i];
            @(negedge clk);
            chk("t1_cmd_ready", {31'b0, cmd_ready}, 1);
        end
        tick();
        cmd_valid = 1'b0;
        wait_idle(30);
        chk("t1_got_at_idle", got.size(), 3);
        tick();
        chk("t1_req_valid_cycles", rv_cnt, 6);
        chk("t1_got_size", got.size(), 3);
        for (int i = 0; i < 3; i++) chk("t1_rd_data", got[i], vals[i]);
        chk("t1_err", {31'b0, err_unexp}, 0);

        // Backpressure on a write
        got.delete();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd5;
        cmd_wdata = 8'd55;
        req_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) tick();
            @(negedge clk);
            chk("t2_req_valid", {31'b0, req_valid}, 1);
            chk("t2_req_addr", {28'b0, req_addr}, 5);
            chk("t2_req_wdata", {24'b0, req_wdata}, 55);
            chk("t2_cmd_ready", {31'b0, cmd_ready}, 0);
        end
        tick();
        req_ready = 1'b1;
        wait_idle(20);
        chk("t2_writes", wr_cnt, 4);

        // Credit limit
        tick();
        rd_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = tbl[acc % 5];
            @(negedge clk);
            if (cmd_ready) acc++;
        end
        chk("t3_reads_accepted", acc, 4);
        chk("t3_cmd_ready_read", {31'b0, cmd_ready}, 0);
        tick();
        cmd_write = 1'b1;
        cmd_addr  = 4'd7;
        cmd_wdata = 8'd77;
        @(negedge clk);
        chk("t3_write_ready", {31'b0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk("t3_rd_valid", {31'b0, rd_valid}, 1);
        chk("t3_rd_data", {24'b0, rd_data}, 10);
        chk("t3_write_done", wr_cnt, 5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 4'd7;
            @(negedge clk);
            if (cmd_ready) acc++;
        end
        chk("t3_reads_after_pop", acc, 1);
        tick();
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        wait_idle(30);
        tick();
        chk("t3_got_size", got.size(), 5);
        for (int i = 0; i < 5; i++) chk("t3_rd_data_seq", got[i], vals[i]);

        // FIFO wrap with toggling rd_ready
        got.delete();
        rd_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 200 && acc < 10; c++) begin
            tick();
            rd_ready  = !rd_ready;
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = tbl[acc % 5];
            @(negedge clk);
            if (cmd_ready) acc++;
        end
        tick();
        cmd_valid = 1'b0;
        rd_ready  = !rd_ready;
        chk("t4_reads_accepted", acc, 10);
        for (int c = 0; c < 100 && got.size() < 10; c++) begin
            tick();
            rd_ready = !rd_ready;
        end
        chk("t4_got_size", got.size(), 10);
        for (int i = 0; i < 10; i++) chk("t4_rd_data_seq", got[i], vals[i % 5]);
        rd_ready = 1'b1;
        wait_idle(20);

        // Unexpected response
        tick();
        chk("t5_err_before", {31'b0, err_unexp}, 0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        @(negedge clk);
        chk("t5_err_set", {31'b0, err_unexp}, 1);
        chk("t5_rd_valid", {31'b0, rd_valid}, 0);
        repeat (3) tick();
        chk("t5_err_sticky", {31'b0, err_unexp}, 1);
        chk("t5_rd_valid_later", {31'b0, rd_valid}, 0);

        // Reset mid-operation: one buffered, two in flight, one held in the request stage
        got.delete();
        rd_ready  = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        hold = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 4'd2;
        tick();
        cmd_addr  = 4'd5;
        tick();
        cmd_addr  = 4'd0;
        tick();
        cmd_valid = 1'b0;
        req_ready = 1'b0;
        @(negedge clk);
        chk("t6_pre_req_valid", {31'b0, req_valid}, 1);
        chk("t6_pre_rd_valid", {31'b0, rd_valid}, 1);
        chk("t6_pre_rd_data", {24'b0, rd_data}, 20);
        chk("t6_pre_cmd_ready", {31'b0, cmd_ready}, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", {31'b0, req_valid}, 0);
        chk("t6_rst_req_write", {31'b0, req_write}, 0);
        chk("t6_rst_req_addr", {28'b0, req_addr}, 0);
        chk("t6_rst_req_wdata", {24'b0, req_wdata}, 0);
        chk("t6_rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("t6_rst_busy", {31'b0, busy}, 0);
        chk("t6_rst_err", {31'b0, err_unexp}, 0);
        pend.delete();
        hold = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("t6_post_rd_valid", {31'b0, rd_valid}, 0);
        chk("t6_post_busy", {31'b0, busy}, 0);
        tick();
        req_ready = 1'b1;
        rd_ready  = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 4'd0;
        tick();
        cmd_valid = 1'b0;
        wait_idle(20);
        tick();
        chk("t6_after_got_size", got.size(), 1);
        chk("t6_after_rd_data", got[0], 10);
        chk("t6_after_err", {31'b0, err_unexp}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
